// File: rtl/edulent_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter for the edulent core's output port.
// Bytes are sent LSB-first; consecutive queued bytes go out with no idle gap between frames.
module edulent_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_wr,
  output logic       o_tx,
  output logic       o_full,
  output logic       o_busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic              push, pop, fifo_empty, baud_end;

  assign fifo_empty = (count_q == '0);
  assign o_full     = (count_q == CntFull);
  // Full is taken from the registered count, so a write on a full edge drops even if we pop.
  assign push       = i_wr & ~o_full;
  assign baud_end   = (baud_q == BaudLast);

  assign o_tx   = tx_q;
  assign o_busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: tb/tb_edulent_uart_tx.sv
// Directed bench for edulent_uart_tx: one 4-clock-per-bit instance and one 868-clock instance.
module tb_edulent_uart_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data, data_big;
  logic       wr, wr_big;
  logic       tx, full, busy;
  logic       tx_big, full_big, busy_big;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  edulent_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_data(data),
    .i_wr  (wr),
    .o_tx  (tx),
    .o_full(full),
    .o_busy(busy)
  );

  edulent_uart_tx #(
    .CLKS_PER_BIT(868),
    .FIFO_DEPTH  (4)
  ) dut_big (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_data(data_big),
    .i_wr  (wr_big),
    .o_tx  (tx_big),
    .o_full(full_big),
    .o_busy(busy_big)
  );

  // Line level at bit slot p (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p >= 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr = 1'b0; data = 8'h00; wr_big = 1'b0; data_big = 8'h00;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({tx, busy, full} !== 3'b100) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d tx/busy/full=%b expected=100", i, {tx, busy, full});
      end
      tests++;
      if ({tx_big, busy_big, full_big} !== 3'b100) begin
        fails++;
        $display("FAIL reset_hold_big cyc=%0d tx/busy/full=%b expected=100", i,
                 {tx_big, busy_big, full_big});
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      tests++;
      if ({tx, busy, full} !== 3'b100) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d tx/busy/full=%b expected=100", i, {tx, busy, full});
      end
    end
  endtask

  task automatic test_single();
    logic exp;
    data = 8'hA5; wr = 1'b1;
    step();
    wr = 1'b0;
    tests++;
    if ({tx, busy, full} !== 3'b110) begin
      fails++;
      $display("FAIL single_accept tx/busy/full=%b expected=110", {tx, busy, full});
    end
    for (int k = 0; k < 40; k++) begin
      step();
      exp = frame_bit(8'hA5, k / 4);
      tests++;
      if (tx !== exp || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_frame k=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, busy, exp);
      end
    end
    step();
    tests++;
    if ({tx, busy} !== 2'b10) begin
      fails++;
      $display("FAIL single_end tx/busy=%b expected=10", {tx, busy});
    end
  endtask

  task automatic test_burst();
    logic exp;
    int   k;
    for (int cyc = 0; cyc <= 201; cyc++) begin
      wr   = (cyc < 6);
      data = 8'(cyc + 1);
      step();
      if (cyc >= 1 && cyc <= 200) begin
        k   = cyc - 1;
        exp = frame_bit(8'(k / 40 + 1), (k % 40) / 4);
        tests++;
        if (tx !== exp) begin
          fails++;
          $display("FAIL burst_frame k=%0d tx=%b expected=%b", k, tx, exp);
        end
      end
      if (cyc == 3 || cyc == 4 || cyc == 5) begin
        tests++;
        if (full !== (cyc != 3)) begin
          fails++;
          $display("FAIL burst_full cyc=%0d full=%b expected=%b", cyc, full, cyc != 3);
        end
      end
      if (cyc == 201) begin
        tests++;
        if ({tx, busy, full} !== 3'b100) begin
          fails++;
          $display("FAIL burst_end tx/busy/full=%b expected=100", {tx, busy, full});
        end
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [7:0] pp [6];
    logic       exp;
    int         k;
    pp = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h5A, 8'h96};
    for (int cyc = 0; cyc <= 241; cyc++) begin
      wr   = 1'b0;
      data = 8'h00;
      if (cyc < 4) begin
        wr = 1'b1; data = pp[cyc];
      end else if (cyc == 41 || cyc == 42) begin
        wr = 1'b1; data = pp[cyc - 37];
      end
      step();
      if (cyc >= 1 && cyc <= 240) begin
        k   = cyc - 1;
        exp = frame_bit(pp[k / 40], (k % 40) / 4);
        tests++;
        if (tx !== exp) begin
          fails++;
          $display("FAIL pushpop_frame k=%0d tx=%b expected=%b", k, tx, exp);
        end
      end
      if (cyc == 3 || cyc == 41 || cyc == 42) begin
        tests++;
        if (full !== (cyc == 42)) begin
          fails++;
          $display("FAIL pushpop_full cyc=%0d full=%b expected=%b", cyc, full, cyc == 42);
        end
      end
      if (cyc == 241) begin
        tests++;
        if ({tx, busy, full} !== 3'b100) begin
          fails++;
          $display("FAIL pushpop_end tx/busy/full=%b expected=100", {tx, busy, full});
        end
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'h11, 8'h22};
    for (int cyc = 0; cyc <= 18; cyc++) begin
      wr   = (cyc < 3);
      data = (cyc < 3) ? bytes[cyc] : 8'h00;
      step();
    end
    tests++;
    if ({tx, busy} !== 2'b01) begin
      fails++;
      $display("FAIL midrst_pre tx/busy=%b expected=01", {tx, busy});
    end
    rstn = 1'b0;
    #1;
    tests++;
    if ({tx, busy, full} !== 3'b100) begin
      fails++;
      $display("FAIL midrst_async tx/busy/full=%b expected=100", {tx, busy, full});
    end
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      tests++;
      if ({tx, busy, full} !== 3'b100) begin
        fails++;
        $display("FAIL midrst_after cyc=%0d tx/busy/full=%b expected=100", i, {tx, busy, full});
      end
    end
  endtask

  task automatic test_large_divider();
    logic exp;
    data_big = 8'h55; wr_big = 1'b1;
    step();
    wr_big = 1'b0;
    for (int k = 0; k < 8680; k++) begin
      step();
      exp = frame_bit(8'h55, k / 868);
      tests++;
      if (tx_big !== exp) begin
        fails++;
        $display("FAIL big_frame k=%0d tx=%b expected=%b", k, tx_big, exp);
      end
    end
    step();
    tests++;
    if ({tx_big, busy_big} !== 2'b10) begin
      fails++;
      $display("FAIL big_end tx/busy=%b expected=10", {tx_big, busy_big});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_push_pop();
    test_mid_reset();
    test_large_divider();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
